// File: rtl/risc16_control_fsm.sv
// Multi-cycle control FSM for the RISC-16 core: FETCH/DECODE/EXEC/MEM/WB sequencing and strobes.
// Build option: define ILLEGAL_TRAP_EN to trap opcode E into FAULT; otherwise E behaves as NOP.
module risc16_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  input  logic       dmem_ready,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [2:0] alu_op,
  output logic       rf_we,
  output logic [1:0] rf_wsel,
  output logic       dmem_re,
  output logic       dmem_we,
  output logic       busy,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_MOV = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JNZ = 4'hD;
  localparam logic [3:0] OP_ILL = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       is_alu;
  state_t     eoi_state;

  assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_MOV);
  // run is only consulted at instruction boundaries.
  assign eoi_state = run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = 8'd0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_HLT) state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
        else if (opcode == OP_ILL) state_d = S_FAULT;
`endif
        else state_d = S_EXEC;
      end
      S_EXEC: begin
        if ((opcode == OP_LD) || (opcode == OP_ST)) state_d = S_MEM;
        else if ((opcode == OP_LDI) || is_alu)      state_d = S_WB;
        else                                        state_d = eoi_state;
      end
      S_MEM: begin
        // The wait counter only lives while in MEM; it is cleared everywhere else.
        if (dmem_ready) state_d = (opcode == OP_LD) ? S_WB : eoi_state;
        else if (wait_q + 8'd1 == TIMEOUT) state_d = S_FAULT;
        else wait_d = wait_q + 8'd1;
      end
      S_WB:     state_d = eoi_state;
      S_HALT:   state_d = S_HALT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  always_comb begin
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    alu_op  = 3'd0;
    rf_we   = 1'b0;
    rf_wsel = 2'd0;
    dmem_re = 1'b0;
    dmem_we = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      S_EXEC: begin
        alu_op = is_alu ? 3'(opcode - OP_ADD) : 3'd0;
        case (opcode)
          OP_JMP:  pc_load = 1'b1;
          OP_JZ:   pc_load = zero_flag;
          OP_JNZ:  pc_load = ~zero_flag;
          default: pc_load = 1'b0;
        endcase
      end
      S_MEM: begin
        dmem_re = (opcode == OP_LD);
        dmem_we = (opcode == OP_ST);
      end
      S_WB: begin
        rf_we = 1'b1;
        if (opcode == OP_LDI)     rf_wsel = 2'd0;
        else if (opcode == OP_LD) rf_wsel = 2'd2;
        else                      rf_wsel = 2'd1;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_FAULT);
  assign halted  = (state_q == S_HALT);
  assign fault   = (state_q == S_FAULT);
  assign state_o = state_q;

  logic unused_ok;
  assign unused_ok = ^{OP_NOP, OP_ILL};

endmodule

// File: tb/tb_risc16_control_fsm.sv
// Randomized bench for risc16_control_fsm: an instruction-level model expands each instruction
// into its expected per-cycle outputs, which are compared against the DUT cycle by cycle.
module tb_risc16_control_fsm;
  localparam int TO = 15;
  localparam int W  = 17;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       zero_flag = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       ir_load, pc_inc, pc_load, rf_we, dmem_re, dmem_we, busy, halted, fault;
  logic [2:0] alu_op, state_o;
  logic [1:0] rf_wsel;

  risc16_control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero_flag(zero_flag),
    .dmem_ready(dmem_ready), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .alu_op(alu_op), .rf_we(rf_we), .rf_wsel(rf_wsel), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .busy(busy), .halted(halted), .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       run;
    logic       rdy;
    logic [3:0] op;
    logic       zf;
  } stim_t;

  stim_t          stim_q[$];
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   obs_q[$];
  int             vectors = 0;
  int             miscompares = 0;

  // Expected output vector for one cycle; status flags follow from the state alone.
  function automatic logic [W-1:0] vec(input logic [2:0] st, input logic irl, input logic pci,
                                       input logic pcl, input logic [2:0] alu, input logic we,
                                       input logic [1:0] wsel, input logic re, input logic dwe);
    logic b;
    b = (st >= 3'd1) && (st <= 3'd5);
    return {st, irl, pci, pcl, alu, we, wsel, re, dwe, b, st == 3'd6, st == 3'd7};
  endfunction

  function automatic logic [W-1:0] observed();
    return {state_o, ir_load, pc_inc, pc_load, alu_op, rf_we, rf_wsel, dmem_re, dmem_we,
            busy, halted, fault};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic r, input logic rd, input logic [3:0] op, input logic zf,
                      input logic [W-1:0] e);
    stim_t s;
    s.run = r; s.rdy = rd; s.op = op; s.zf = zf;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic model_idle(input int n);
    for (int i = 0; i < n; i++)
      push(i == n - 1, rbit(), 4'($urandom_range(0, 15)), rbit(),
           vec(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0));
  endtask

  task automatic model_hold(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++)
      push(rbit(), rbit(), 4'($urandom_range(0, 15)), rbit(),
           vec(st, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0));
  endtask

  // One instruction: w = not-ready MEM cycles (w >= TO means memory never answers).
  task automatic model_instr(input logic [3:0] op, input int w, input logic run_end);
    logic zf, pcl, last;
    logic [2:0] alu;
    logic [1:0] wsel;
    int n_mem;
    zf = rbit();
    push(rbit(), rbit(), op, rbit(), vec(3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    push(rbit(), rbit(), op, rbit(), vec(3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    if (op == 4'hF) return;
`ifdef ILLEGAL_TRAP_EN
    if (op == 4'hE) return;
`endif
    alu  = (op >= 4'h4 && op <= 4'hA) ? 3'(op - 4'd4) : 3'd0;
    pcl  = (op == 4'hB) || (op == 4'hC && zf) || (op == 4'hD && !zf);
    last = op inside {4'h0, 4'hB, 4'hC, 4'hD, 4'hE};
    push(last ? run_end : rbit(), rbit(), op, zf,
         vec(3'd3, 1'b0, 1'b0, pcl, alu, 1'b0, 2'd0, 1'b0, 1'b0));
    if (op == 4'h2 || op == 4'h3) begin
      n_mem = (w >= TO) ? TO : w + 1;
      for (int i = 0; i < n_mem; i++)
        push((op == 4'h3 && i == w) ? run_end : rbit(), i == w, op, rbit(),
             vec(3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, op == 4'h2, op == 4'h3));
      if (w >= TO) return;
    end
    if (op == 4'h1 || op == 4'h2 || (op >= 4'h4 && op <= 4'hA)) begin
      wsel = (op == 4'h1) ? 2'd0 : (op == 4'h2) ? 2'd2 : 2'd1;
      push(run_end, rbit(), op, rbit(), vec(3'd5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, wsel, 1'b0, 1'b0));
    end
    if (!run_end) model_idle($urandom_range(1, 3));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1 time unit later.
  task automatic play();
    stim_t s;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(negedge clk);
      run = s.run; dmem_ready = s.rdy; opcode = s.op; zero_flag = s.zf;
      #1;
      obs_q.push_back(observed());
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] o;
    reset = 1'b1; run = 1'b1; dmem_ready = 1'b1; opcode = 4'h4;
    repeat (2) @(posedge clk);
    #1;
    o = observed();
    vectors++;
    if (o !== vec(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", o, vec(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_nop_ldi();
    logic [W-1:0] e, o; int n = 0;
    do_reset();
    model_idle(1);
    model_instr(4'h0, 0, 1'b1);
    model_instr(4'h1, 0, 1'b1);
    model_instr(4'h0, 0, 1'b0);
    model_instr(4'h1, 0, 1'b0);
    play();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL nop_ldi cycle %0d: got %h expected %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_alu();
    logic [W-1:0] e, o; int n = 0;
    do_reset();
    model_idle(1);
    model_instr(4'h4, 0, 1'b1);
    model_instr(4'h5, 0, 1'b1);
    for (int i = 0; i < 7; i++) model_instr(4'(4 + i), 0, rbit());
    play();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL alu_ops cycle %0d: got %h expected %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_mem();
    logic [W-1:0] e, o; int n = 0;
    do_reset();
    model_idle(1);
    model_instr(4'h2, 3, 1'b1);
    model_instr(4'h3, 0, 1'b1);
    model_instr(4'h2, 0, 1'b0);
    model_instr(4'h3, 2, 1'b0);
    model_instr(4'h2, TO - 1, 1'b1);
    model_instr(4'h3, TO - 1, 1'b1);
    play();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL mem_access cycle %0d: got %h expected %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_jumps();
    logic [W-1:0] e, o; int n = 0;
    do_reset();
    model_idle(1);
    for (int i = 0; i < 12; i++) model_instr(4'(11 + (i % 3)), 0, rbit());
    play();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL jumps cycle %0d: got %h expected %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] e, o; int n = 0;
    do_reset();
    model_idle(1);
    model_instr(4'h3, TO, 1'b1);
    model_hold(3'd7, 6);
    play();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL mem_timeout cycle %0d: got %h expected %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_halt();
    logic [W-1:0] e, o; int n = 0;
    do_reset();
    model_idle(1);
    model_instr(4'h4, 0, 1'b1);
    model_instr(4'hF, 0, 1'b1);
    model_hold(3'd6, 10);
    play();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL halt cycle %0d: got %h expected %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_opcode_e();
    logic [W-1:0] e, o; int n = 0;
    do_reset();
    model_idle(1);
    model_instr(4'hE, 0, 1'b1);
`ifdef ILLEGAL_TRAP_EN
    model_hold(3'd7, 5);
`else
    model_instr(4'h1, 0, 1'b1);
`endif
    play();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL opcode_e cycle %0d: got %h expected %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] o, z;
    z = vec(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    do_reset();
    run = 1'b1; opcode = 4'h2; dmem_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    o = observed(); vectors++;
    if (o !== vec(3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0)) begin
      miscompares++; $display("FAIL areset_in_mem: got %h expected %h", o, vec(3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0));
    end
    #1 reset = 1'b1;
    #1;
    o = observed(); vectors++;
    if (o !== z) begin miscompares++; $display("FAIL areset_immediate: got %h expected %h", o, z); end
    @(posedge clk); #1;
    o = observed(); vectors++;
    if (o !== z) begin miscompares++; $display("FAIL areset_held: got %h expected %h", o, z); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    o = observed(); vectors++;
    if (o !== vec(3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0)) begin
      miscompares++; $display("FAIL areset_restart: got %h expected %h", o, vec(3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e, o; int n = 0;
    logic [3:0] op;
    do_reset();
    model_idle($urandom_range(1, 3));
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 14));
`ifdef ILLEGAL_TRAP_EN
      if (op == 4'hE) op = 4'h0;
`endif
      model_instr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2), rbit());
    end
    play();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL random_stream cycle %0d: got %h expected %h", n, o, e); end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_nop_ldi();
    test_alu();
    test_mem();
    test_jumps();
    test_timeout();
    test_halt();
    test_opcode_e();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
